// File: rtl/sw_led_io.sv
// Switch debouncer with rising-edge detect feeding a registered LED driver.
// The LED driver shows the debounced switches, toggle bits, edge count or a blink pattern.
module sw_led_io #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int BLINK_DIV       = 12500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic [1:0]       mode,
  input  logic             clr,
  output logic [WIDTH-1:0] led,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] sw_rise
);

  // The extra bit keeps DEBOUNCE_CYCLES-1 representable for any parameter value.
  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int PW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PW-1:0] PS_LAST = PW'(BLINK_DIV - 1);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;
  logic [CW-1:0]    cnt [WIDTH];
  logic [WIDTH-1:0] tog;
  logic [WIDTH-1:0] ecnt;
  logic [PW-1:0]    ps_cnt;
  logic             phase;

  // Stage p0/p1: two-flop synchronizer, the only consumer of raw sw
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= sw;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
      sw_db   <= '0;
      sw_rise <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        sw_rise[i] <= 1'b0;
        if (sync_p1[i] == sw_db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          cnt[i]     <= '0;
          sw_db[i]   <= sync_p1[i];
          sw_rise[i] <= sync_p1[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Edge consumers: clr has priority over a coincident rising edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tog  <= '0;
      ecnt <= '0;
    end else if (clr) begin
      tog  <= '0;
      ecnt <= '0;
    end else begin
      tog <= tog ^ sw_rise;
      if (|sw_rise) ecnt <= ecnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ps_cnt <= '0;
      phase  <= 1'b0;
    end else if (ps_cnt == PS_LAST) begin
      ps_cnt <= '0;
      phase  <= ~phase;
    end else begin
      ps_cnt <= ps_cnt + 1'b1;
    end
  end

  // Output stage: LED source select, one cycle behind its source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      case (mode)
        2'd0:    led <= sw_db;
        2'd1:    led <= tog;
        2'd2:    led <= sw_db & {WIDTH{phase}};
        default: led <= ecnt;
      endcase
    end
  end

endmodule
